// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SRAM port between the
// instruction-fetch port and the load/store port, one transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W/8-1:0]   d_we,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [STRB_W-1:0]   we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                i_rvalid_q, i_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                grant_i, grant_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        i_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the port that did not win last time gets the slot.
                if (i_req && (!d_req || last_grant_q))
                    grant_i = 1'b1;
                else if (d_req)
                    grant_d = 1'b1;

                if (grant_i || grant_d) begin
                    owner_d      = grant_d;
                    last_grant_d = grant_d;
                    addr_d       = grant_d ? d_addr  : i_addr;
                    we_d         = grant_d ? d_we    : '0;
                    wdata_d      = grant_d ? d_wdata : '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 3'(MEM_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        if (we_q == '0)
                            d_rdata_d = mem_rdata;
                    end else begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            we_q         <= '0;
            wdata_q      <= '0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign i_ack     = grant_i & ~rst;
    assign d_ack     = grant_d & ~rst;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    // The SRAM bus is driven only in the issue cycle and is quiet otherwise.
    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en ? we_q    : '0;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
endmodule
